// File: rtl/vend_ctrl_multi.sv
// vend_ctrl_multi
//   Multi-product vending controller. Coin credit is counted in half-dollar
//   units. A selection is served when the credit covers that item's price.
//   Any remainder, or the whole credit on cancel, is paid back one
//   half-dollar per cycle.
//
// Ports
//   clk, reset          clock; synchronous active-high reset
//   half_dollar         coin strobe, +1 unit
//   one_dollar          coin strobe, +2 units
//   sel_valid, sel_idx  product selection strobe and index
//   cancel              refund request
//   dispense, collect   1-cycle pulses when a product is released
//   item_idx            index of the released product (held between vends)
//   half_out            1-cycle pulse per half-dollar returned
//   coin_reject         this cycle's coins were refused
//   sel_err             selection refused
//   credit              current credit in units
//   busy                vending or paying change
module vend_ctrl_multi #(
    parameter int                       NUM_ITEMS  = 4,
    parameter int                       SEL_W      = 2,
    parameter int                       CW         = 6,
    parameter logic [NUM_ITEMS*CW-1:0]  PRICES     = {6'd8, 6'd4, 6'd3, 6'd5},
    parameter int                       MAX_CREDIT = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             half_dollar,
    input  logic             one_dollar,
    input  logic             sel_valid,
    input  logic [SEL_W-1:0] sel_idx,
    input  logic             cancel,
    output logic             dispense,
    output logic [SEL_W-1:0] item_idx,
    output logic             collect,
    output logic             half_out,
    output logic             coin_reject,
    output logic             sel_err,
    output logic [CW-1:0]    credit,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, CREDIT, VEND, CHANGE} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      credit_q, credit_d;
    logic [SEL_W-1:0]   item_idx_q, item_idx_d;
    logic               dispense_q, dispense_d;
    logic               collect_q, collect_d;
    logic               half_out_q, half_out_d;
    logic               coin_reject_q, coin_reject_d;
    logic               sel_err_q, sel_err_d;
    logic               busy_q, busy_d;

    logic [CW-1:0]      sel_price;
    logic               sel_known;
    logic               sel_ok;
    logic [1:0]         coin_add;
    logic [CW:0]        coin_sum;
    logic               coin_fits;
    logic               coin_take;

    // Price of the selected item; indices beyond NUM_ITEMS are unknown items.
    always_comb begin
        sel_known = 1'b0;
        sel_price = '0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            if (int'(sel_idx) == i) begin
                sel_known = 1'b1;
                sel_price = PRICES[i*CW +: CW];
            end
        end
    end

    // {one, half} read as a 2-bit number is exactly half + 2*one.
    assign coin_add  = {one_dollar, half_dollar};
    assign coin_sum  = {1'b0, credit_q} + {{(CW-1){1'b0}}, coin_add};
    assign coin_fits = coin_sum <= (CW+1)'(MAX_CREDIT);
    assign sel_ok    = sel_known && (credit_q >= sel_price);

    // Next-state and registered-output logic. Entering CHANGE already emits
    // the first half-dollar, so CHANGE and half_out=1 always coincide; the
    // pulse that brings credit to 0 is still a CHANGE cycle and the state
    // drops to IDLE after it.
    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        item_idx_d    = item_idx_q;
        dispense_d    = 1'b0;
        collect_d     = 1'b0;
        half_out_d    = 1'b0;
        coin_reject_d = 1'b0;
        sel_err_d     = 1'b0;
        coin_take     = 1'b0;

        case (state_q)
            IDLE, CREDIT: begin
                if (cancel) begin
                    if (state_q == CREDIT) begin
                        state_d    = CHANGE;
                        half_out_d = 1'b1;
                        credit_d   = credit_q - CW'(1);
                    end
                end else if (sel_valid && (state_q == CREDIT) && sel_ok) begin
                    state_d    = VEND;
                    dispense_d = 1'b1;
                    collect_d  = 1'b1;
                    item_idx_d = sel_idx;
                    credit_d   = credit_q - sel_price;
                end else begin
                    sel_err_d = sel_valid;
                    coin_take = 1'b1;
                end

                if (coin_add != 2'b00) begin
                    if (coin_take && coin_fits) begin
                        credit_d = coin_sum[CW-1:0];
                        state_d  = CREDIT;
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                end
            end

            VEND, CHANGE: begin
                coin_reject_d = (coin_add != 2'b00);
                if (credit_q != '0) begin
                    state_d    = CHANGE;
                    half_out_d = 1'b1;
                    credit_d   = credit_q - CW'(1);
                end else begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == VEND) || (state_d == CHANGE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            credit_q      <= '0;
            item_idx_q    <= '0;
            dispense_q    <= 1'b0;
            collect_q     <= 1'b0;
            half_out_q    <= 1'b0;
            coin_reject_q <= 1'b0;
            sel_err_q     <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            item_idx_q    <= item_idx_d;
            dispense_q    <= dispense_d;
            collect_q     <= collect_d;
            half_out_q    <= half_out_d;
            coin_reject_q <= coin_reject_d;
            sel_err_q     <= sel_err_d;
            busy_q        <= busy_d;
        end
    end

    assign dispense    = dispense_q;
    assign item_idx    = item_idx_q;
    assign collect     = collect_q;
    assign half_out    = half_out_q;
    assign coin_reject = coin_reject_q;
    assign sel_err     = sel_err_q;
    assign credit      = credit_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_vend_ctrl_multi.sv
// tb_vend_ctrl_multi
//   Directed bench for vend_ctrl_multi. A behavioural model tracks credit as
//   a plain integer plus "vending" / "refunding" flags and predicts every
//   output each cycle. A negedge process compares the DUT against it. The
//   directed sequences add literal expectations on credit, pulse counts and
//   busy time.
module tb_vend_ctrl_multi;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       half_dollar = 1'b0;
    logic       one_dollar = 1'b0;
    logic       sel_valid = 1'b0;
    logic [1:0] sel_idx = 2'd0;
    logic       cancel = 1'b0;
    logic       dispense;
    logic [1:0] item_idx;
    logic       collect;
    logic       half_out;
    logic       coin_reject;
    logic       sel_err;
    logic [5:0] credit;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int half_count = 0;
    int busy_count = 0;

    int   m_credit = 0;
    bit   m_vend = 1'b0;
    bit   m_refund = 1'b0;
    bit   model_valid = 1'b0;
    logic e_dispense = 1'b0;
    logic e_collect = 1'b0;
    logic e_half = 1'b0;
    logic e_reject = 1'b0;
    logic e_sel_err = 1'b0;
    logic e_busy = 1'b0;
    int   e_item = 0;
    int   price_tab [4] = '{5, 3, 4, 8};

    always #5 clk = ~clk;

    vend_ctrl_multi dut (
        .clk         (clk),
        .reset       (reset),
        .half_dollar (half_dollar),
        .one_dollar  (one_dollar),
        .sel_valid   (sel_valid),
        .sel_idx     (sel_idx),
        .cancel      (cancel),
        .dispense    (dispense),
        .item_idx    (item_idx),
        .collect     (collect),
        .half_out    (half_out),
        .coin_reject (coin_reject),
        .sel_err     (sel_err),
        .credit      (credit),
        .busy        (busy)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Model step: credit zero means idle, otherwise credit is held; a vend
    // lasts one cycle, then any remainder is paid back one unit per cycle.
    task automatic step_model();
        int add;
        bit coin_ok;
        add         = int'(half_dollar) + 2 * int'(one_dollar);
        coin_ok     = 1'b0;
        e_dispense  = 1'b0;
        e_collect   = 1'b0;
        e_half      = 1'b0;
        e_reject    = 1'b0;
        e_sel_err   = 1'b0;
        if (reset) begin
            m_credit    = 0;
            m_vend      = 1'b0;
            m_refund    = 1'b0;
            e_item      = 0;
            model_valid = 1'b1;
        end else if (m_vend || m_refund) begin
            m_vend   = 1'b0;
            e_reject = (add > 0);
            if (m_credit > 0) begin
                e_half   = 1'b1;
                m_credit = m_credit - 1;
                m_refund = 1'b1;
            end else begin
                m_refund = 1'b0;
            end
        end else begin
            if (cancel) begin
                if (m_credit > 0) begin
                    e_half   = 1'b1;
                    m_credit = m_credit - 1;
                    m_refund = 1'b1;
                end
            end else if (sel_valid && m_credit > 0 && m_credit >= price_tab[int'(sel_idx)]) begin
                e_dispense = 1'b1;
                e_collect  = 1'b1;
                e_item     = int'(sel_idx);
                m_credit   = m_credit - price_tab[int'(sel_idx)];
                m_vend     = 1'b1;
            end else begin
                e_sel_err = sel_valid;
                coin_ok   = 1'b1;
            end
            if (add > 0) begin
                if (coin_ok && (m_credit + add <= 20)) m_credit = m_credit + add;
                else e_reject = 1'b1;
            end
        end
        e_busy = m_vend || m_refund;
    endtask

    always @(posedge clk) step_model();

    always @(negedge clk) begin
        if (model_valid) begin
            checkOutput("dispense", int'(dispense), int'(e_dispense));
            checkOutput("collect", int'(collect), int'(e_collect));
            checkOutput("item_idx", int'(item_idx), e_item);
            checkOutput("half_out", int'(half_out), int'(e_half));
            checkOutput("coin_reject", int'(coin_reject), int'(e_reject));
            checkOutput("sel_err", int'(sel_err), int'(e_sel_err));
            checkOutput("credit", int'(credit), m_credit);
            checkOutput("busy", int'(busy), int'(e_busy));
        end
    end

    // Drives one cycle of inputs starting at a negedge and returns at the
    // following negedge, when the registered response is visible.
    task automatic applyStimulus(input bit h, input bit o, input bit s,
                                 input logic [1:0] idx, input bit c, input bit r);
        half_dollar = h;
        one_dollar  = o;
        sel_valid   = s;
        sel_idx     = idx;
        cancel      = c;
        reset       = r;
        @(posedge clk);
        #1;
        half_dollar = 1'b0;
        one_dollar  = 1'b0;
        sel_valid   = 1'b0;
        sel_idx     = 2'd0;
        cancel      = 1'b0;
        reset       = 1'b0;
        @(negedge clk);
        half_count += int'(half_out);
        busy_count += int'(busy);
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(0, 0, 0, 2'd0, 0, 0);
    endtask

    task automatic ones(input int n);
        repeat (n) applyStimulus(0, 1, 0, 2'd0, 0, 0);
    endtask

    initial begin
        @(negedge clk);
        applyStimulus(0, 0, 0, 2'd0, 0, 1);
        applyStimulus(0, 0, 0, 2'd0, 0, 1);
        checkOutput("T1 reset credit", int'(credit), 0);
        checkOutput("T1 reset busy", int'(busy), 0);

        // 1: exact payment for item 0
        applyStimulus(1, 0, 0, 2'd0, 0, 0);
        ones(2);
        checkOutput("T1 credit 5", int'(credit), 5);
        half_count = 0;
        applyStimulus(0, 0, 1, 2'd0, 0, 0);
        checkOutput("T1 dispense", int'(dispense), 1);
        checkOutput("T1 collect", int'(collect), 1);
        checkOutput("T1 credit 0", int'(credit), 0);
        idle(2);
        checkOutput("T1 no change", half_count, 0);
        checkOutput("T1 busy low", int'(busy), 0);

        // 2: item 1 from 6 units leaves 3 in change
        ones(3);
        checkOutput("T2 credit 6", int'(credit), 6);
        half_count = 0;
        busy_count = 0;
        applyStimulus(0, 0, 1, 2'd1, 0, 0);
        checkOutput("T2 item_idx", int'(item_idx), 1);
        checkOutput("T2 credit 3", int'(credit), 3);
        idle(1);
        checkOutput("T2 credit 2", int'(credit), 2);
        idle(2);
        checkOutput("T2 credit 0", int'(credit), 0);
        idle(2);
        checkOutput("T2 half pulses", half_count, 3);
        checkOutput("T2 busy cycles", busy_count, 4);

        // 3: unaffordable item, then cancel refund
        ones(2);
        applyStimulus(0, 0, 1, 2'd3, 0, 0);
        checkOutput("T3 sel_err", int'(sel_err), 1);
        checkOutput("T3 credit 4", int'(credit), 4);
        half_count = 0;
        applyStimulus(0, 0, 0, 2'd0, 1, 0);
        idle(5);
        checkOutput("T3 refund pulses", half_count, 4);
        checkOutput("T3 credit 0", int'(credit), 0);

        // 4: credit ceiling
        ones(10);
        checkOutput("T4 credit 20", int'(credit), 20);
        applyStimulus(0, 1, 0, 2'd0, 0, 0);
        checkOutput("T4 reject at 20", int'(coin_reject), 1);
        checkOutput("T4 credit held 20", int'(credit), 20);
        half_count = 0;
        applyStimulus(0, 0, 0, 2'd0, 1, 0);
        idle(21);
        checkOutput("T4 refund 20", half_count, 20);
        ones(9);
        applyStimulus(1, 1, 0, 2'd0, 0, 0);
        checkOutput("T4 reject both", int'(coin_reject), 1);
        checkOutput("T4 credit held 18", int'(credit), 18);

        // 5: inputs during CHANGE are refused, change count unaffected
        half_count = 0;
        applyStimulus(0, 0, 1, 2'd0, 0, 0);
        checkOutput("T5 credit 13", int'(credit), 13);
        applyStimulus(0, 1, 1, 2'd2, 0, 0);
        checkOutput("T5 reject in change", int'(coin_reject), 1);
        checkOutput("T5 no sel_err", int'(sel_err), 0);
        checkOutput("T5 credit 12", int'(credit), 12);
        idle(13);
        checkOutput("T5 change pulses", half_count, 13);

        // 5b: reset during the second refund pulse abandons the refund
        ones(2);
        half_count = 0;
        applyStimulus(0, 0, 0, 2'd0, 1, 0);
        idle(1);
        checkOutput("T5 second pulse", int'(half_out), 1);
        applyStimulus(0, 0, 0, 2'd0, 0, 1);
        checkOutput("T5 reset half_out", int'(half_out), 0);
        checkOutput("T5 reset credit", int'(credit), 0);
        checkOutput("T5 reset busy", int'(busy), 0);
        idle(3);
        checkOutput("T5 pulses after reset", half_count, 2);

        // 6: cancel beats selection and coin in the same cycle
        ones(2);
        applyStimulus(0, 1, 1, 2'd1, 1, 0);
        checkOutput("T6 refund pulse", int'(half_out), 1);
        checkOutput("T6 coin_reject", int'(coin_reject), 1);
        checkOutput("T6 no dispense", int'(dispense), 0);
        checkOutput("T6 no sel_err", int'(sel_err), 0);
        checkOutput("T6 credit 3", int'(credit), 3);
        idle(4);
        checkOutput("T6 credit 0", int'(credit), 0);
        checkOutput("T6 busy low", int'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vend_ctrl_multi.md
Name: vend_ctrl_multi

Overview:
Parametrised vending controller, successor to the single-product half/one-dollar seller. It accumulates coin credit in half-dollar units and serves NUM_ITEMS products with individually configured prices. It returns change or a cancel refund one half-dollar per cycle. It sits between the coin acceptor front end and the dispenser/change-hopper drivers.

Parameters:
NUM_ITEMS, 4, number of selectable products
SEL_W, 2, width of sel_idx; must satisfy 2**SEL_W >= NUM_ITEMS
CW, 6, credit/price width in half-dollar units
PRICES, {6'd8,6'd4,6'd3,6'd5}, packed NUM_ITEMS*CW prices, item0 in LSBs (item0=5 units, i.e. 2.5 dollars)
MAX_CREDIT, 20, maximum credit held, in units; must be < 2**CW

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
half_dollar  in  1  half-dollar coin strobe (+1 unit), 1 cycle per coin
one_dollar  in  1  one-dollar coin strobe (+2 units), 1 cycle per coin
sel_valid  in  1  product selection strobe
sel_idx  in  SEL_W  selected product index
cancel  in  1  refund request
dispense  out  1  1-cycle pulse, product released
item_idx  out  SEL_W  product index, valid while dispense=1, holds otherwise
collect  out  1  1-cycle pulse, coins banked; coincident with dispense
half_out  out  1  1-cycle pulse per half-dollar returned
coin_reject  out  1  1-cycle pulse, this cycle's coin(s) refused
sel_err  out  1  1-cycle pulse, selection refused
credit  out  CW  current credit, in units
busy  out  1  high in VEND and CHANGE

Behaviour:
- All outputs are registered. Every register has exactly one driving always block.
- Reset (sync): state=IDLE, credit=0, item_idx=0, all pulse outputs 0, busy=0. A reset asserted mid-VEND or mid-CHANGE abandons the operation. Outputs are 0 on the cycle after the reset edge.
- States: IDLE (credit=0), CREDIT, VEND, CHANGE.
- Coin add per cycle = half_dollar + 2*one_dollar. Both strobes in one cycle add 3.
- Coin acceptance rules:
  - Coins are accepted only in IDLE/CREDIT, and only when no cancel or accepted selection occurs in the same cycle.
  - A coin is accepted only if credit+add <= MAX_CREDIT.
  - Otherwise coin_reject=1 next cycle and credit is unchanged. The whole cycle's add is refused; there is no partial accept.
  - An accepted coin in IDLE moves the state to CREDIT.
- Priority within IDLE/CREDIT: cancel > sel_valid > coins.
- cancel handling:
  - In CREDIT: go to CHANGE, refunding the full credit.
  - In IDLE: no effect.
  - In VEND/CHANGE: ignored.
- sel_valid in CREDIT is compared against the registered credit.
  - If sel_idx >= NUM_ITEMS or credit < PRICES[sel_idx]: sel_err=1 next cycle; state and credit are unchanged.
  - Otherwise go to VEND. On the next cycle dispense=1, collect=1, item_idx=sel_idx, and credit = credit - price.
- sel_valid in IDLE gives sel_err. In VEND/CHANGE it is ignored with no sel_err.
- Latency: selection accepted at edge N gives dispense high during cycle N+1.
- VEND lasts 1 cycle. If the remainder > 0, go to CHANGE; otherwise go to IDLE.
- CHANGE: each cycle half_out=1 and credit decrements by 1. The total number of half_out pulses equals the entry credit, back to back with no gaps. The cycle in which credit reaches 0 carries the last pulse, then the state goes to IDLE.
- Coins in VEND/CHANGE: coin_reject=1.
- No arithmetic overflow is possible because MAX_CREDIT < 2**CW. A price of 0 is legal: dispense with full credit returned.

Test Plan:
1. Reset; half, one, one (credit 5); sel_idx=0 -> dispense and collect 1 cycle, item_idx=0, no half_out, credit=0, state IDLE, busy low.
2. one x3 (credit 6); sel_idx=1 (price 3) -> dispense, then 3 consecutive half_out pulses; credit reads 3,2,1,0; busy high for 4 cycles total.
3. one x2 (credit 4); sel_idx=3 (price 8) -> sel_err pulse, credit stays 4; then cancel -> exactly 4 half_out pulses, credit 0.
4. one x10 (credit 20); one_dollar again -> coin_reject, credit 20. half_dollar and one_dollar in the same cycle at credit 18 -> reject, credit 18.
5. During CHANGE, apply one_dollar and sel_valid -> coin_reject only, change count unaffected. Reset asserted at the 2nd half_out -> all outputs 0 next cycle, no further half_out.
6. In CREDIT, cancel, sel_valid and one_dollar in the same cycle -> refund taken, coin_reject=1, no dispense, no sel_err.
